// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles and publishes the count once per window with a one-cycle strobe.
// Optional feature macro: DUTY_MEAS_EN adds high_out, the number of clk
// cycles the synchronised input was high during the same window.
//
// Handshake: freq_valid is a one-cycle strobe with no ready; freq_out, ovf
// (and high_out) change only in the cycle freq_valid is 1 and hold otherwise.
// State visibility: busy is the registered FSM state (1 = MEASURE).
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
`ifdef DUTY_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_out
`endif
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MEASURE = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_s;
  logic                   rise;

  logic [0:0]       state_q;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;
  logic             last_cycle;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign rise       = sync_s & ~prev_q;
  assign last_cycle = (gate_cnt == GATE_LAST);

  // Synchroniser and edge history; runs in every state so the first
  // window cycle already sees a valid previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_s;
    end
  end

  // Saturating edge count including the current cycle's rise; an increment
  // dropped at the ceiling marks the window as overflowed.
  always_comb begin
    edge_next = edge_cnt;
    sat_next  = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt + CNT_W'(1);
      end
    end
  end

  // Gate FSM: window timing, counting, publish and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy       <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      ovf        <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (state_q == S_IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
        if (en) begin
          state_q <= S_MEASURE;
          busy    <= 1'b1;
        end
      end else if (last_cycle) begin
        // The final window cycle always publishes, even if en just dropped;
        // the next window starts on the same edge so no rise is lost.
        freq_out   <= edge_next;
        ovf        <= sat_next;
        freq_valid <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        sat        <= 1'b0;
        if (!en) begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      end else if (!en) begin
        // Abort: partial count is discarded, published values hold.
        state_q  <= S_IDLE;
        busy     <= 1'b0;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_next;
        sat      <= sat_next;
      end
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] high_next;

  // Saturating high-time count including the current cycle.
  always_comb begin
    high_next = high_cnt;
    if (sync_s && (high_cnt != CNT_MAX)) begin
      high_next = high_cnt + CNT_W'(1);
    end
  end

  // High-time counter follows the same window, publish and abort rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt <= '0;
      high_out <= '0;
    end else if (state_q == S_IDLE) begin
      high_cnt <= '0;
    end else if (last_cycle) begin
      high_out <= high_next;
      high_cnt <= '0;
    end else if (!en) begin
      high_cnt <= '0;
    end else begin
      high_cnt <= high_next;
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: two instances (32-bit/2-stage and 4-bit/3-stage)
// share one stimulus plan; expectations come from a window-level model over
// the planned input sequences.
module tb_freq_meter;

  localparam int G = 100;
  localparam int N = 3000;

  // ---------------- clock / reset block ----------------
  logic clk;
  logic rst;
  logic en;
  logic sig_in;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] fo_a;
  logic        fv_a, ovf_a, busy_a;
  logic [3:0]  fo_b;
  logic        fv_b, ovf_b, busy_b;
`ifdef DUTY_MEAS_EN
  logic [31:0] hi_a;
  logic [3:0]  hi_b;
`endif

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(fo_a), .freq_valid(fv_a), .ovf(ovf_a), .busy(busy_a)
`ifdef DUTY_MEAS_EN
    , .high_out(hi_a)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(fo_b), .freq_valid(fv_b), .ovf(ovf_b), .busy(busy_b)
`ifdef DUTY_MEAS_EN
    , .high_out(hi_b)
`endif
  );

  // ---------------- stimulus plan and captured outputs ----------------
  bit rst_p[N];
  bit en_p[N];
  bit sig_p[N];

  logic [63:0] got_fo[2][N];
  logic        got_fv[2][N];
  logic        got_ovf[2][N];
  logic        got_busy[2][N];
`ifdef DUTY_MEAS_EN
  logic [63:0] got_hi[2][N];
`endif

  logic [63:0] exp_q[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Square wave: period p clk, high for the first h cycles of each period.
  task automatic gen_seg(input int lo, input int hi_e, input int p, input int h);
    for (int i = lo; i < hi_e && i < N; i++) sig_p[i] = ((i - lo) % p) < h;
  endtask

  task automatic build_plan();
    int k;
    int len;
    for (int i = 0; i < N; i++) begin
      rst_p[i] = (i < 3);
      en_p[i]  = (i >= 3);
      sig_p[i] = 1'b0;
    end
    // en low sampled on a final window edge (303), abort mid-window (370),
    // reset pulse mid-window (640).
    for (int i = 303; i < 310; i++) en_p[i] = 1'b0;
    for (int i = 370; i < 380; i++) en_p[i] = 1'b0;
    rst_p[640] = 1'b1;
    rst_p[641] = 1'b1;
    gen_seg(0, 350, 10, 5);
    gen_seg(350, 550, 20, 10);
    gen_seg(550, 850, 2, 1);
    gen_seg(850, 950, 10, 5);
    gen_seg(950, 1050, 1, 1);
    k = 1050;
    while (k < N) begin
      int p;
      len = $urandom_range(50, 300);
      p   = $urandom_range(2, 40);
      gen_seg(k, k + len, p, $urandom_range(0, p));
      k += len;
    end
    for (int i = 1050; i < N; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        len = $urandom_range(1, 15);
        for (int m = i; m < i + len && m < N; m++) en_p[m] = 1'b0;
      end
      if ($urandom_range(0, 999) == 0) begin
        len = $urandom_range(1, 3);
        for (int m = i; m < i + len && m < N; m++) rst_p[m] = 1'b1;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronised input seen after edge j: the input sampled ns-1 edges
  // earlier, forced to 0 if a reset edge fell anywhere in that span.
  function automatic bit y_at(input int j, input int ns);
    int k0;
    k0 = j - ns + 1;
    if (k0 < 0) return 1'b0;
    for (int m = k0; m <= j; m++) if (rst_p[m]) return 1'b0;
    return sig_p[k0];
  endfunction

  task automatic score(input int d);
    int          ns;
    logic [63:0] maxv;
    bit          meas;
    int          a;
    logic [63:0] fo;
    bit          ov;
    bit          v;
    logic [63:0] n;
    string       nm;
`ifdef DUTY_MEAS_EN
    logic [63:0] h;
    logic [63:0] hv;
    hv = '0;
`endif
    ns   = (d == 0) ? 2 : 3;
    maxv = (d == 0) ? 64'hFFFF_FFFF : 64'd15;
    nm   = (d == 0) ? "a" : "b";
    meas = 1'b0;
    a    = 0;
    fo   = '0;
    ov   = 1'b0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      v = 1'b0;
      if (rst_p[k]) begin
        meas = 1'b0;
        fo   = '0;
        ov   = 1'b0;
`ifdef DUTY_MEAS_EN
        hv   = '0;
`endif
      end else if (!meas) begin
        if (en_p[k]) begin
          meas = 1'b1;
          a    = k;
        end
      end else if (k == a + G) begin
        n = '0;
`ifdef DUTY_MEAS_EN
        h = '0;
`endif
        for (int j = a; j < a + G; j++) begin
          n = n + 64'(y_at(j, ns) & ~y_at(j - 1, ns));
`ifdef DUTY_MEAS_EN
          h = h + 64'(y_at(j, ns));
`endif
        end
        fo = (n > maxv) ? maxv : n;
        ov = (n > maxv);
`ifdef DUTY_MEAS_EN
        hv = (h > maxv) ? maxv : h;
`endif
        v  = 1'b1;
        exp_q.push_back(fo);
        if (en_p[k]) a = k;
        else meas = 1'b0;
      end else if (!en_p[k]) begin
        meas = 1'b0;
      end
      check($sformatf("%s valid@%0d", nm, k), 64'(got_fv[d][k]), 64'(v));
      check($sformatf("%s busy@%0d", nm, k), 64'(got_busy[d][k]), 64'(meas));
      check($sformatf("%s freq_out@%0d", nm, k), got_fo[d][k], fo);
      check($sformatf("%s ovf@%0d", nm, k), 64'(got_ovf[d][k]), 64'(ov));
`ifdef DUTY_MEAS_EN
      check($sformatf("%s high_out@%0d", nm, k), got_hi[d][k], hv);
`endif
    end
    // Strobe-ordered scoreboard: each DUT strobe consumes one expected value.
    for (int k = 0; k < N; k++) begin
      if (got_fv[d][k] === 1'b1) begin
        if (exp_q.size() == 0) check($sformatf("%s extra_strobe@%0d", nm, k), 64'd1, 64'd0);
        else check($sformatf("%s strobe_val@%0d", nm, k), got_fo[d][k], exp_q.pop_front());
      end
    end
    check($sformatf("%s missing_strobes", nm), 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- driver: play plan, capture outputs ----------------
  initial begin
    build_plan();
    rst    = rst_p[0];
    en     = en_p[0];
    sig_in = sig_p[0];
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      got_fo[0][k]   = 64'(fo_a);
      got_fv[0][k]   = fv_a;
      got_ovf[0][k]  = ovf_a;
      got_busy[0][k] = busy_a;
      got_fo[1][k]   = 64'(fo_b);
      got_fv[1][k]   = fv_b;
      got_ovf[1][k]  = ovf_b;
      got_busy[1][k] = busy_b;
`ifdef DUTY_MEAS_EN
      got_hi[0][k]   = 64'(hi_a);
      got_hi[1][k]   = 64'(hi_b);
`endif
      if (k + 1 < N) begin
        rst    = rst_p[k + 1];
        en     = en_p[k + 1];
        sig_in = sig_p[k + 1];
      end
    end
    score(0);
    score(1);
    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
